pe_mac_sequencer: RTL
=====================

Name: pe_mac_sequencer

Overview:
- Clocked controller that feeds one PE function unit (FU): 3-tap filter × 3-bit spike window → 12-bit psum.
- Parses the 26-bit PE packet stream and keeps the loaded filter and a sliding spike window per ifmap row.
- Issues one FU operation per new spike once the window holds 3 bits of the current row.
- Buffers returned psums in an output FIFO with valid/ready backpressure. Sits between the PE input router port and the psum output router port.

Parameters:
- ROW_W, 8, ifmap row length in spikes; window resets at row end; legal range 3..255.
- OUT_DEPTH, 4, psum output FIFO depth; power of 2, at least 2.
- PSUM_W, 12, psum width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  packet valid.
- in_ready  out  1  packet accepted when in_valid && in_ready.
- in_data  in  26  [25]=active (0 = clear packet); [24]=1 filter / 0 ifmap; [23:0] filter taps {f2,f1,f0}; [0] spike for ifmap packets.
- fu_req_valid  out  1  FU operation request.
- fu_req_ready  in  1  FU accepts request.
- fu_filter  out  24  filter taps for the op.
- fu_window  out  3  spike window {oldest..newest}.
- fu_rsp_valid  in  1  FU psum valid (single-cycle pulse).
- fu_rsp_psum  in  PSUM_W  FU result.
- out_valid  out  1  psum available.
- out_ready  in  1  consumer pops.
- out_psum  out  PSUM_W  FIFO head.
- ops_done  out  16  count of psums written to the FIFO; wraps at 0xFFFF→0.
- row_done  out  1  one-cycle pulse when the last spike of a row is accepted.

Behaviour:
- Reset values:
  - in_ready=1; fu_req_valid=0, fu_filter=0, fu_window=0.
  - out_valid=0, out_psum=0 (don't-care while invalid; driven 0).
  - ops_done=0, row_done=0.
  - Internal: filter_reg=0, filter_ok=0, window=0, col_cnt=0, FIFO empty, state=IDLE.
- Reset mid-operation: all of the above takes effect the next edge. An in-flight FU response arriving after reset is discarded.
- FSM states: IDLE, REQ, WAIT.
  - in_ready = (state==IDLE).
- IDLE, packet accepted:
  - Clear (bit25=0): filter_reg=0, filter_ok=0, window=0, col_cnt=0. FIFO and ops_done untouched.
  - Filter (bit25=1, bit24=1): filter_reg=in_data[23:0], filter_ok=1. Window and col_cnt unchanged, so a mid-row filter swap applies to later ops only.
  - Ifmap (bit25=1, bit24=0): window={window[1:0],in_data[0]}, col_cnt+1. Issue condition = (col_cnt_new ≥ 3) && filter_ok.
    - Issue condition true → REQ next cycle; fu_filter/fu_window latched with post-shift values.
    - Issue condition false → ifmap is shifted only.
- Row end: when the accepted ifmap makes col_cnt_new == ROW_W:
  - row_done pulses the next cycle.
  - col_cnt→0 and window→0 after the latched op values are captured.
  - The last window is still issued.
- REQ:
  - fu_req_valid=1 only while FIFO count + 0 outstanding < OUT_DEPTH. This is a slot reservation: the outstanding op always has a FIFO slot.
  - On fu_req_valid && fu_req_ready → WAIT.
- WAIT:
  - On fu_rsp_valid: push fu_rsp_psum, ops_done+1, → IDLE.
  - One outstanding op maximum.
- Latency with FU ready and responding same cycle:
  - Ifmap accepted at cycle t → fu_req_valid at t+1.
  - Response at cycle r → out_valid at r+1.
  - Next packet accepted at r+1.
- FIFO:
  - Push and pop in the same cycle is allowed, including when full (pop frees a slot first).
  - out_psum = head entry, registered.
  - Pop when empty and push when full are impossible by construction; assertion fires if violated.
- fu_rsp_valid outside WAIT is ignored and flagged by assertion.
- Arithmetic: the controller does no arithmetic on psum; it passes PSUM_W bits unchanged.

Decomposition:
- Shared package pe_pkg:
  - Packet field constants: PKT_ACTIVE_BIT=25, PKT_FILT_BIT=24, FILT_W=24, SPIKE_BIT=0.
  - PSUM_W default.
  - Enum seq_state_t {IDLE,REQ,WAIT}.
- One sub-module: psum_fifo (parameterised depth/width, synchronous reset, count output), instantiated once.

Test Plan:
- Filter 0x030201, spikes 1,1,1 (ROW_W=8); bench FU computes w2*f2+w1*f1+w0*f0 → one request with fu_window=3'b111; psum 6 out; ops_done=1.
- Continue spikes 0,1 → windows 3'b110 and 3'b101 → psums 5 and 4, in order.
- ROW_W=4, filter 0x010101, spikes 1,1,1,1,1,1,1 → 2 psums for row 0 (3,3), row_done after spike 4, window cleared, row 1 first op after spike 7 → 3; exactly 3 psums total.
- out_ready=0, OUT_DEPTH=4, 6 issuable spikes → 4 psums buffered, fu_req_valid held 0, in_ready 0; raise out_ready → remaining 2 issued, order preserved.
- Spikes before any filter, then clear packet, then filter 0x000001 and spikes 0,0,1 → no requests before filter; single psum 1 after.
- Assert rst for one cycle while in WAIT, then FU responds → response dropped, FIFO empty, ops_done=0, in_ready=1 the cycle after reset.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE MAC sequencer.
// Holds the PE packet field layout, the default psum width and the
// controller state encoding used by pe_mac_sequencer.
package pe_pkg;

    // 26-bit PE packet: [25]=active, [24]=filter/ifmap, [23:0]=taps, [0]=spike
    localparam int PKT_W          = 26;
    localparam int PKT_ACTIVE_BIT = 25;
    localparam int PKT_FILT_BIT   = 24;
    localparam int FILT_W         = 24;
    localparam int SPIKE_BIT      = 0;

    // The FU consumes a 3-bit spike window per operation
    localparam int WIN_W          = 3;

    localparam int PSUM_W_DEF     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/psum_fifo.sv
// Psum output FIFO.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write din_i this cycle
//   din_i     : entry to write
//   pop_i     : drop the head entry this cycle
//   head_o    : current head entry, 0 while empty
//   empty_o   : no entries stored
//   count_o   : number of stored entries (0..DEPTH)
// Push and pop together are legal even when full: the pop frees the slot
// that the push then fills, so the count is unchanged.
module psum_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push_i && full && !pop_i));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop_i && empty_o));

endmodule

// File: rtl/pe_mac_sequencer.sv
// PE MAC sequencer: parses the PE packet stream, keeps the loaded filter
// and a sliding 3-spike window per ifmap row, issues one FU operation per
// new spike once the window is full, and buffers returned psums.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : 26-bit packet input (valid/ready)
//   fu_req_valid/fu_req_ready     : FU operation handshake
//   fu_filter, fu_window          : operands latched for the issued op
//   fu_rsp_valid, fu_rsp_psum     : single-cycle FU result
//   out_valid/out_ready/out_psum  : psum output (FIFO head)
//   ops_done                      : psums written to the FIFO (wraps)
//   row_done                      : pulse after the last spike of a row
module pe_mac_sequencer
    import pe_pkg::*;
#(
    parameter int ROW_W     = 8,
    parameter int OUT_DEPTH = 4,
    parameter int PSUM_W    = PSUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  in_data,
    output logic              fu_req_valid,
    input  logic              fu_req_ready,
    output logic [FILT_W-1:0] fu_filter,
    output logic [WIN_W-1:0]  fu_window,
    input  logic              fu_rsp_valid,
    input  logic [PSUM_W-1:0] fu_rsp_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_psum,
    output logic [15:0]       ops_done,
    output logic              row_done
);

    localparam int COL_W = $clog2(ROW_W + 1);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    seq_state_t        state_q, state_d;
    logic [FILT_W-1:0] filter_q, filter_d;
    logic              filt_ok_q, filt_ok_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [FILT_W-1:0] fu_filter_q, fu_filter_d;
    logic [WIN_W-1:0]  fu_window_q, fu_window_d;
    logic              row_done_q, row_done_d;
    logic [15:0]       ops_q, ops_d;
    // Set by reset: a response still in flight from before reset may
    // arrive outside WAIT and is dropped without tripping the assertion.
    logic              stale_q, stale_d;

    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [WIN_W-1:0]  win_new;
    logic [COL_W-1:0]  col_new;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            filter_q    <= '0;
            filt_ok_q   <= 1'b0;
            win_q       <= '0;
            col_q       <= '0;
            fu_filter_q <= '0;
            fu_window_q <= '0;
            row_done_q  <= 1'b0;
            ops_q       <= '0;
            stale_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            filter_q    <= filter_d;
            filt_ok_q   <= filt_ok_d;
            win_q       <= win_d;
            col_q       <= col_d;
            fu_filter_q <= fu_filter_d;
            fu_window_q <= fu_window_d;
            row_done_q  <= row_done_d;
            ops_q       <= ops_d;
            stale_q     <= stale_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && issue)               state_d = REQ;
            REQ:     if (fu_req_valid && fu_req_ready)  state_d = WAIT;
            WAIT:    if (fu_rsp_valid)                  state_d = IDLE;
            default:                                    state_d = IDLE;
        endcase
    end

    // FSM outputs. A request is only raised while the FIFO has room, so the
    // outstanding op always owns a free slot when its psum returns.
    always_comb begin
        in_ready     = (state_q == IDLE);
        fu_req_valid = (state_q == REQ) && (fifo_cnt < DEPTH_C);
        push         = (state_q == WAIT) && fu_rsp_valid;
    end

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Packet decode, window/column tracking and op latching
    always_comb begin
        filter_d    = filter_q;
        filt_ok_d   = filt_ok_q;
        win_d       = win_q;
        col_d       = col_q;
        fu_filter_d = fu_filter_q;
        fu_window_d = fu_window_q;
        row_done_d  = 1'b0;
        ops_d       = ops_q;
        stale_d     = stale_q;
        issue       = 1'b0;
        win_new     = {win_q[WIN_W-2:0], in_data[SPIKE_BIT]};
        col_new     = col_q + 1'b1;

        if (accept) begin
            if (!in_data[PKT_ACTIVE_BIT]) begin
                filter_d  = '0;
                filt_ok_d = 1'b0;
                win_d     = '0;
                col_d     = '0;
            end else if (in_data[PKT_FILT_BIT]) begin
                filter_d  = in_data[FILT_W-1:0];
                filt_ok_d = 1'b1;
            end else begin
                issue = (col_new >= COL_W'(WIN_W)) && filt_ok_q;
                if (issue) begin
                    fu_filter_d = filter_q;
                    fu_window_d = win_new;
                end
                // Operands were captured above, so the final window of the
                // row is still issued before the window is cleared.
                if (col_new == COL_W'(ROW_W)) begin
                    row_done_d = 1'b1;
                    col_d      = '0;
                    win_d      = '0;
                end else begin
                    col_d = col_new;
                    win_d = win_new;
                end
            end
        end

        if (push) begin
            ops_d = ops_q + 16'd1;
        end
        if ((fu_req_valid && fu_req_ready) || fu_rsp_valid) begin
            stale_d = 1'b0;
        end
    end

    psum_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (PSUM_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (fu_rsp_psum),
        .pop_i   (pop),
        .head_o  (out_psum),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign out_valid = !fifo_empty;
    assign fu_filter = fu_filter_q;
    assign fu_window = fu_window_q;
    assign ops_done  = ops_q;
    assign row_done  = row_done_q;

    a_rsp_in_wait : assert property (@(posedge clk) disable iff (rst)
        fu_rsp_valid |-> ((state_q == WAIT) || stale_q));

endmodule
